// File: rtl/alu_pkg.sv
// Opcode encoding and opcode-class helpers shared by the alu_v3 datapath
// and the blocks that drive it.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_ADDI = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_MUL  = 3'd3,
        ALU_MULI = 3'd4,
        ALU_MAC  = 3'd5,
        ALU_CLR  = 3'd6,
        ALU_RSVD = 3'd7
    } alu_op_t;

    // Number of defined opcodes (ADD..CLR); the reserved code sits past the end.
    localparam int ALU_OP_COUNT = 7;

    function automatic logic op_uses_imm(input alu_op_t op);
        return (op == ALU_ADDI) || (op == ALU_MULI);
    endfunction

    function automatic logic op_is_mul(input alu_op_t op);
        return (op == ALU_MUL) || (op == ALU_MULI) || (op == ALU_MAC);
    endfunction

    // CLR and every code beyond it (the reserved one) clear the accumulator.
    function automatic logic op_is_clr(input alu_op_t op);
        return int'(op) >= (ALU_OP_COUNT - 1);
    endfunction

endpackage

// File: rtl/sfixed_narrow.sv
// Narrows a wide two's complement value to OUT_W bits by clamping or
// wrapping, flagging any value outside the OUT_W signed range.
module sfixed_narrow #(
    parameter int IN_W   = 17,
    parameter int OUT_W  = 8,
    parameter bit SAT_EN = 1'b1
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    ovf
);

    localparam int HI_W = IN_W - OUT_W + 1;

    logic [HI_W-1:0] hi_bits;

    always_comb begin
        // In range exactly when every bit from the OUT_W sign bit upward agrees.
        hi_bits = din[IN_W-1:OUT_W-1];
        ovf     = !((&hi_bits) || !(|hi_bits));
        dout    = din[OUT_W-1:0];
        if (ovf && SAT_EN) begin
            dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/alu_v3.sv
// Three-stage signed fixed-point ALU with a multiply-accumulate register,
// global-stall valid/ready handshakes and saturate-or-wrap narrowing.
module alu_v3
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int FRAC_BITS = 0,
    parameter bit SAT_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  alu_op_t              op,
    input  logic [BUS_WIDTH-1:0] data_a,
    input  logic [BUS_WIDTH-1:0] data_b,
    input  logic [BUS_WIDTH-1:0] imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] result,
    output logic                 ovf
);

    localparam int W  = BUS_WIDTH;
    localparam int PW = 2 * BUS_WIDTH;

    logic                 advance;

    logic                 vld_p1_d, vld_p1_q;
    alu_op_t              op_p1_d, op_p1_q;
    logic signed [W-1:0]  opa_p1_d, opa_p1_q;
    logic signed [W-1:0]  opb_p1_d, opb_p1_q;

    logic signed [PW-1:0] a_ext_p1, b_ext_p1;
    logic                 vld_p2_d, vld_p2_q;
    alu_op_t              op_p2_d, op_p2_q;
    logic signed [PW-1:0] raw_p2_d, raw_p2_q;

    logic signed [PW-1:0] scaled_p3;
    logic signed [PW:0]   mac_sum_p3;
    logic signed [W-1:0]  direct_res_p3, mac_res_p3;
    logic                 direct_ovf_p3, mac_ovf_p3;
    logic                 out_valid_d, out_valid_q;
    logic signed [W-1:0]  result_d, result_q;
    logic                 ovf_d, ovf_q;
    logic signed [W-1:0]  acc_d, acc_q;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    // ---- S1: capture opcode and selected operands ----
    always_comb begin
        vld_p1_d = vld_p1_q;
        op_p1_d  = op_p1_q;
        opa_p1_d = opa_p1_q;
        opb_p1_d = opb_p1_q;
        if (advance) begin
            vld_p1_d = in_valid;
            op_p1_d  = op;
            opa_p1_d = data_a;
            opb_p1_d = op_uses_imm(op) ? imm : data_b;
        end
    end

    // ---- S2: full-precision sum or product ----
    assign a_ext_p1 = {{W{opa_p1_q[W-1]}}, opa_p1_q};
    assign b_ext_p1 = {{W{opb_p1_q[W-1]}}, opb_p1_q};

    always_comb begin
        vld_p2_d = vld_p2_q;
        op_p2_d  = op_p2_q;
        raw_p2_d = raw_p2_q;
        if (advance) begin
            vld_p2_d = vld_p1_q;
            op_p2_d  = op_p1_q;
            case (op_p1_q)
                ALU_ADD, ALU_ADDI:          raw_p2_d = a_ext_p1 + b_ext_p1;
                ALU_SUB:                    raw_p2_d = a_ext_p1 - b_ext_p1;
                ALU_MUL, ALU_MULI, ALU_MAC: raw_p2_d = a_ext_p1 * b_ext_p1;
                default:                    raw_p2_d = '0;
            endcase
        end
    end

    // ---- S3: scale, accumulate, narrow ----
    always_comb begin
        scaled_p3  = op_is_mul(op_p2_q) ? (raw_p2_q >>> FRAC_BITS) : raw_p2_q;
        mac_sum_p3 = {{(PW-W+1){acc_q[W-1]}}, acc_q} + {scaled_p3[PW-1], scaled_p3};
    end

    sfixed_narrow #(.IN_W(PW), .OUT_W(W), .SAT_EN(SAT_EN)) u_narrow_direct (
        .din  (scaled_p3),
        .dout (direct_res_p3),
        .ovf  (direct_ovf_p3)
    );

    sfixed_narrow #(.IN_W(PW+1), .OUT_W(W), .SAT_EN(SAT_EN)) u_narrow_mac (
        .din  (mac_sum_p3),
        .dout (mac_res_p3),
        .ovf  (mac_ovf_p3)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        acc_d       = acc_q;
        if (advance) begin
            out_valid_d = vld_p2_q;
            if (vld_p2_q) begin
                if (op_is_clr(op_p2_q)) begin
                    result_d = '0;
                    ovf_d    = 1'b0;
                    acc_d    = '0;
                end else if (op_p2_q == ALU_MAC) begin
                    result_d = mac_res_p3;
                    ovf_d    = mac_ovf_p3;
                    acc_d    = mac_res_p3;
                end else begin
                    result_d = direct_res_p3;
                    ovf_d    = direct_ovf_p3;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
        end
    end

    // Operand/raw payload only matters when its stage valid is set.
    always_ff @(posedge clk) begin
        op_p1_q  <= op_p1_d;
        opa_p1_q <= opa_p1_d;
        opb_p1_q <= opb_p1_d;
        op_p2_q  <= op_p2_d;
        raw_p2_q <= raw_p2_d;
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_v3.sv
// Bench for alu_v3: three instances (saturate, wrap, FRAC_BITS=4) share one
// stimulus stream and are checked against a per-instance arithmetic model.
module tb_alu_v3;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, out_ready;
    alu_op_t    op;
    logic [7:0] data_a, data_b, imm;

    logic       in_ready_s, in_ready_w, in_ready_f;
    logic       out_valid_s, out_valid_w, out_valid_f;
    logic [7:0] result_s, result_w, result_f;
    logic       ovf_s, ovf_w, ovf_f;

    always #5 clk = ~clk;

    alu_v3 #(.BUS_WIDTH(8), .FRAC_BITS(0), .SAT_EN(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .op(op),
        .data_a(data_a), .data_b(data_b), .imm(imm), .out_valid(out_valid_s),
        .out_ready(out_ready), .result(result_s), .ovf(ovf_s));

    alu_v3 #(.BUS_WIDTH(8), .FRAC_BITS(0), .SAT_EN(1'b0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .op(op),
        .data_a(data_a), .data_b(data_b), .imm(imm), .out_valid(out_valid_w),
        .out_ready(out_ready), .result(result_w), .ovf(ovf_w));

    alu_v3 #(.BUS_WIDTH(8), .FRAC_BITS(4), .SAT_EN(1'b1)) dut_f (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_f), .op(op),
        .data_a(data_a), .data_b(data_b), .imm(imm), .out_valid(out_valid_f),
        .out_ready(out_ready), .result(result_f), .ovf(ovf_f));

    int total = 0;
    int bad   = 0;

    longint     acc_s, acc_w, acc_f;
    logic [8:0] exp_qs[$], exp_qw[$], exp_qf[$];
    logic [8:0] got_s, got_w, got_f, exp_s, exp_w, exp_f;
    bit         got_out, accepted;

    // Reference: evaluate one op on a signed 8-bit format, returns {ovf, result}.
    function automatic logic [8:0] model(input int op_i, input longint a, input longint b,
                                         input longint im, input int frac, input bit sat,
                                         inout longint acc);
        longint full, w;
        bit     ov;
        full = 0;
        case (op_i)
            0: full = a + b;
            1: full = a + im;
            2: full = a - b;
            3: full = (a * b) >>> frac;
            4: full = (a * im) >>> frac;
            5: full = acc + ((a * b) >>> frac);
            default: begin
                acc = 0;
                return 9'h000;
            end
        endcase
        ov = (full > 127) || (full < -128);
        if (!ov) w = full;
        else if (sat) w = (full > 127) ? 127 : -128;
        else begin
            w = full % 256;
            if (w > 127) w -= 256;
            if (w < -128) w += 256;
        end
        if (op_i == 5) acc = w;
        return {ov, w[7:0]};
    endfunction

    task automatic model_reset();
        acc_s = 0; acc_w = 0; acc_f = 0;
        exp_qs.delete(); exp_qw.delete(); exp_qf.delete();
    endtask

    // Advances one clock: samples outputs and handshakes at the falling edge,
    // feeds accepted ops into the model, returns just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        got_out  = out_valid_s && out_valid_w && out_valid_f && out_ready;
        accepted = in_valid && in_ready_s && in_ready_w && in_ready_f;
        got_s = {ovf_s, result_s};
        got_w = {ovf_w, result_w};
        got_f = {ovf_f, result_f};
        exp_s = 'x; exp_w = 'x; exp_f = 'x;
        if (got_out) begin
            if (exp_qs.size() > 0) exp_s = exp_qs.pop_front();
            if (exp_qw.size() > 0) exp_w = exp_qw.pop_front();
            if (exp_qf.size() > 0) exp_f = exp_qf.pop_front();
        end
        if (accepted) begin
            exp_qs.push_back(model(int'(op), longint'($signed(data_a)), longint'($signed(data_b)),
                                   longint'($signed(imm)), 0, 1'b1, acc_s));
            exp_qw.push_back(model(int'(op), longint'($signed(data_a)), longint'($signed(data_b)),
                                   longint'($signed(imm)), 0, 1'b0, acc_w));
            exp_qf.push_back(model(int'(op), longint'($signed(data_a)), longint'($signed(data_b)),
                                   longint'($signed(imm)), 4, 1'b1, acc_f));
        end
        @(posedge clk);
        #1;
    endtask

    // Issue one op into an idle pipe and wait (bounded) for its result.
    task automatic one_op(input alu_op_t o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] im, output bit timed_out);
        op = o; data_a = a; data_b = b; imm = im; in_valid = 1'b1;
        cycle();
        in_valid  = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 8 && timed_out; i++) begin
            cycle();
            if (got_out) timed_out = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = ALU_ADD;
        data_a = '0; data_b = '0; imm = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_valid_s, ovf_s, result_s} !== 10'h000) begin
            bad++; $display("FAIL reset_outputs got=%h want=000", {out_valid_s, ovf_s, result_s});
        end
        total++;
        if (in_ready_s !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready_s);
        end
        rst = 1'b0;
        cycle();
        total++;
        if (in_ready_s !== 1'b1 || out_valid_s !== 1'b0) begin
            bad++; $display("FAIL post_reset got=%b%b want=10", in_ready_s, out_valid_s);
        end
    endtask

    task automatic test_directed_ops();
        bit to;
        one_op(ALU_ADD, 8'd100, 8'd50, 8'd0, to);
        total++;
        if (to || got_s !== 9'h17F) begin
            bad++; $display("FAIL add_sat got=%h want=17f timeout=%b", got_s, to);
        end
        total++;
        if (to || got_w !== 9'h196) begin
            bad++; $display("FAIL add_wrap got=%h want=196 timeout=%b", got_w, to);
        end
        one_op(ALU_SUB, 8'h9C, 8'd50, 8'd0, to);
        total++;
        if (to || got_s !== 9'h180) begin
            bad++; $display("FAIL sub_sat got=%h want=180 timeout=%b", got_s, to);
        end
        one_op(ALU_ADDI, 8'd5, 8'h77, 8'd3, to);
        total++;
        if (to || got_s !== 9'h008) begin
            bad++; $display("FAIL addi got=%h want=008 timeout=%b", got_s, to);
        end
        one_op(ALU_MUL, 8'h18, 8'h28, 8'd0, to);
        total++;
        if (to || got_f !== 9'h03C) begin
            bad++; $display("FAIL mul_frac4 got=%h want=03c timeout=%b", got_f, to);
        end
        one_op(ALU_MULI, 8'hFD, 8'h11, 8'd5, to);
        total++;
        if (to || got_s !== 9'h0F1) begin
            bad++; $display("FAIL muli got=%h want=0f1 timeout=%b", got_s, to);
        end
    endtask

    task automatic test_back_to_back_mac();
        alu_op_t    ops[4]    = '{ALU_CLR, ALU_MAC, ALU_MAC, ALU_MAC};
        logic [7:0] av[4]     = '{8'd0, 8'd10, 8'd10, 8'd1};
        logic [8:0] want_s[4] = '{9'h000, 9'h064, 9'h17F, 9'h17F};
        logic [8:0] want_w[4] = '{9'h000, 9'h064, 9'h1C8, 9'h0C9};
        logic [8:0] obs_s[4], obs_w[4];
        int rcv = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 12 && rcv < 4; i++) begin
            in_valid = (i < 4);
            if (i < 4) begin
                op = ops[i]; data_a = av[i]; data_b = av[i];
            end
            cycle();
            if (got_out) begin
                obs_s[rcv] = got_s; obs_w[rcv] = got_w; rcv++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (rcv != 4) begin
            bad++; $display("FAIL mac_count got=%0d want=4", rcv);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_s[i] !== want_s[i]) begin
                bad++; $display("FAIL mac_sat[%0d] got=%h want=%h", i, obs_s[i], want_s[i]);
            end
            total++;
            if (obs_w[i] !== want_w[i]) begin
                bad++; $display("FAIL mac_wrap[%0d] got=%h want=%h", i, obs_w[i], want_w[i]);
            end
        end
    endtask

    task automatic test_stall();
        int sent = 0, rcv = 0, hold = 0;
        bit stall_done = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
            if (out_valid_s && !stall_done) begin
                hold = 4; stall_done = 1'b1;
            end
            out_ready = (hold == 0);
            if (hold > 0) hold--;
            in_valid = (sent < 5);
            op = ALU_ADD; data_a = 8'(sent + 1); data_b = 8'd0;
            #1;
            if (!out_ready && out_valid_s) begin
                total++;
                if (in_ready_s !== 1'b0) begin
                    bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready_s);
                end
            end
            cycle();
            if (accepted) sent++;
            if (got_out) begin
                total++;
                if (got_s !== {1'b0, 8'(rcv + 1)}) begin
                    bad++; $display("FAIL stall_order[%0d] got=%h want=%h", rcv, got_s, {1'b0, 8'(rcv + 1)});
                end
                rcv++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++;
        if (rcv != 5 || !stall_done) begin
            bad++; $display("FAIL stall_count got=%0d want=5", rcv);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int ghosts = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op = ALU_MAC; data_a = 8'(i + 2); data_b = 8'd5;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        total++;
        if (out_valid_s !== 1'b1) begin
            bad++; $display("FAIL midrst_stalled got=%b want=1", out_valid_s);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid_s, ovf_s, result_s} !== 10'h000) begin
            bad++; $display("FAIL midrst_outputs got=%h want=000", {out_valid_s, ovf_s, result_s});
        end
        total++;
        if (in_ready_s !== 1'b1) begin
            bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready_s);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (got_out) ghosts++;
        end
        total++;
        if (ghosts != 0) begin
            bad++; $display("FAIL midrst_flush got=%0d want=0", ghosts);
        end
        one_op(ALU_MAC, 8'd2, 8'd3, 8'd0, to);
        total++;
        if (to || got_s !== 9'h006) begin
            bad++; $display("FAIL midrst_mac got=%h want=006 timeout=%b", got_s, to);
        end
    endtask

    function automatic logic [7:0] rnd8();
        if ($urandom_range(0, 1) == 0) return 8'($urandom);
        return 8'(int'($urandom_range(0, 16)) - 8);
    endfunction

    task automatic test_random();
        for (int n = 0; n < 330; n++) begin
            in_valid  = (n < 300) && ($urandom_range(0, 3) != 0);
            op        = alu_op_t'($urandom_range(0, 7));
            data_a    = rnd8();
            data_b    = rnd8();
            imm       = rnd8();
            out_ready = (n >= 300) || ($urandom_range(0, 9) < 7);
            cycle();
            if (got_out) begin
                total++;
                if (got_s !== exp_s) begin
                    bad++; $display("FAIL rand_sat got=%h want=%h", got_s, exp_s);
                end
                total++;
                if (got_w !== exp_w) begin
                    bad++; $display("FAIL rand_wrap got=%h want=%h", got_w, exp_w);
                end
                total++;
                if (got_f !== exp_f) begin
                    bad++; $display("FAIL rand_frac got=%h want=%h", got_f, exp_f);
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (exp_qs.size() != 0) begin
            bad++; $display("FAIL rand_drain got=%0d want=0", exp_qs.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed_ops();
        test_back_to_back_mac();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
